// File: rtl/i2c_apb_seq.sv
// i2c_apb_seq: command sequencer and sole APB master of an apb_i2c peripheral.
// Turns a valid/ready stream of byte-level I2C commands into the APB access
// sequence TX load, CMD write, STATUS polling, RX read and IRQ acknowledge.
// It returns exactly one response word per accepted command.
//
// Ports:
//   HCLK, HRESETn        clock, asynchronous active-low reset
//   prescaler_i[15:0]    value written to PRE during init
//   cfg_update_i         pulse; re-runs init when sampled in IDLE
//   cmd_valid_i/ready_o  command handshake, cmd_data_i = {tx_byte, cmd}
//   rsp_valid_o/ready_i  response handshake, rsp_data_o = {err, al, rxack, rx}
//   busy_o               sequencer is not in IDLE
//   state_o[3:0]         current FSM state (debug visibility)
//   PADDR..PSLVERR       APB master port
//
// Handshakes: a transfer happens on a rising HCLK edge where valid and ready
// are both 1. Once raised, rsp_valid_o and rsp_data_o hold until that edge.
// The sequencer drives cmd_ready_o only while it is in IDLE.
module i2c_apb_seq #(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter logic [15:0] POLL_TIMEOUT   = 16'hFFFF
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [15:0]               prescaler_i,
  input  logic                      cfg_update_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic [15:0]               cmd_data_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [10:0]               rsp_data_o,
  output logic                      busy_o,
  output logic [3:0]                state_o,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  typedef enum logic [3:0] {
    S_INIT_PRE  = 4'd0,
    S_INIT_CTRL = 4'd1,
    S_IDLE      = 4'd2,
    S_WR_TX     = 4'd3,
    S_WR_CMD    = 4'd4,
    S_POLL      = 4'd5,
    S_RD_RX     = 4'd6,
    S_WR_IACK   = 4'd7,
    S_RESP      = 4'd8
  } state_e;

  // Phase of the APB access owned by the current state. PH_IDLE is the
  // mandatory bus-idle cycle that follows every completion.
  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_SETUP  = 2'd1,
    PH_ACCESS = 2'd2
  } phase_e;

  localparam logic [7:0] ADDR_PRE    = 8'h00;
  localparam logic [7:0] ADDR_CTRL   = 8'h04;
  localparam logic [7:0] ADDR_RX     = 8'h08;
  localparam logic [7:0] ADDR_STATUS = 8'h0C;
  localparam logic [7:0] ADDR_TX     = 8'h10;
  localparam logic [7:0] ADDR_CMD    = 8'h14;

  state_e      state_q;
  phase_e      phase_q;
  logic [7:0]  tx_q;
  logic [4:0]  op_q;        // cmd[7:3]: STA, STO, RD, WR, ACK
  logic        err_q;
  logic        al_q;
  logic        rxack_q;
  logic [7:0]  rx_q;
  logic [15:0] poll_cnt_q;
  logic [15:0] poll_cnt_d;

  logic [7:0]  acc_addr;
  logic        acc_write;
  logic [31:0] acc_wdata;

  // Access descriptor for the state about to issue a SETUP.
  always_comb begin
    acc_addr  = ADDR_PRE;
    acc_write = 1'b1;
    acc_wdata = 32'h0;
    case (state_q)
      S_INIT_PRE:  begin acc_addr = ADDR_PRE;    acc_wdata = {16'h0, prescaler_i}; end
      S_INIT_CTRL: begin acc_addr = ADDR_CTRL;   acc_wdata = 32'h80; end
      S_WR_TX:     begin acc_addr = ADDR_TX;     acc_wdata = {24'h0, tx_q}; end
      S_WR_CMD:    begin acc_addr = ADDR_CMD;    acc_wdata = {24'h0, op_q, 3'b000}; end
      S_POLL:      begin acc_addr = ADDR_STATUS; acc_write = 1'b0; end
      S_RD_RX:     begin acc_addr = ADDR_RX;     acc_write = 1'b0; end
      S_WR_IACK:   begin acc_addr = ADDR_CMD;    acc_wdata = 32'h1; end
      default:     begin acc_addr = ADDR_PRE;    acc_write = 1'b1; end
    endcase
  end

  // Saturating so a huge POLL_TIMEOUT can never wrap the counter.
  assign poll_cnt_d = (poll_cnt_q == 16'hFFFF) ? poll_cnt_q : poll_cnt_q + 16'd1;

  assign cmd_ready_o = (state_q == S_IDLE);
  assign busy_o      = ~cmd_ready_o;
  assign state_o     = state_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= S_INIT_PRE;
      phase_q     <= PH_IDLE;
      tx_q        <= 8'h0;
      op_q        <= 5'h0;
      err_q       <= 1'b0;
      al_q        <= 1'b0;
      rxack_q     <= 1'b0;
      rx_q        <= 8'h0;
      poll_cnt_q  <= 16'h0;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= 11'h0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= 32'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // An accepted command wins over a simultaneous cfg_update_i.
          if (cmd_valid_i) begin
            tx_q       <= cmd_data_i[15:8];
            op_q       <= cmd_data_i[7:3];
            err_q      <= 1'b0;
            al_q       <= 1'b0;
            rxack_q    <= 1'b0;
            rx_q       <= 8'h0;
            poll_cnt_q <= 16'h0;
            state_q    <= cmd_data_i[4] ? S_WR_TX : S_WR_CMD;
          end else if (cfg_update_i) begin
            state_q <= S_INIT_PRE;
          end
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          case (phase_q)
            PH_IDLE: begin
              PSEL    <= 1'b1;
              PENABLE <= 1'b0;
              PADDR   <= APB_ADDR_WIDTH'(acc_addr);
              PWRITE  <= acc_write;
              PWDATA  <= acc_wdata;
              phase_q <= PH_SETUP;
            end
            PH_SETUP: begin
              PENABLE <= 1'b1;
              phase_q <= PH_ACCESS;
            end
            default: begin
              if (PREADY) begin
                PSEL    <= 1'b0;
                PENABLE <= 1'b0;
                phase_q <= PH_IDLE;
                if (PSLVERR) err_q <= 1'b1;
                case (state_q)
                  S_INIT_PRE:  state_q <= S_INIT_CTRL;
                  S_INIT_CTRL: state_q <= S_IDLE;
                  S_WR_TX:     state_q <= S_WR_CMD;
                  S_WR_CMD:    state_q <= S_POLL;
                  S_POLL: begin
                    if (PRDATA[0]) begin
                      al_q    <= PRDATA[5];
                      rxack_q <= PRDATA[7];
                      // Lost arbitration means there is no byte worth reading.
                      state_q <= (op_q[2] && !PRDATA[5]) ? S_RD_RX : S_WR_IACK;
                    end else begin
                      poll_cnt_q <= poll_cnt_d;
                      if (poll_cnt_d >= POLL_TIMEOUT) begin
                        err_q   <= 1'b1;
                        state_q <= S_WR_IACK;
                      end
                    end
                  end
                  S_RD_RX: begin
                    rx_q    <= PRDATA[7:0];
                    state_q <= S_WR_IACK;
                  end
                  S_WR_IACK: begin
                    rsp_valid_o <= 1'b1;
                    rsp_data_o  <= {err_q | PSLVERR, al_q, rxack_q, rx_q};
                    state_q     <= S_RESP;
                  end
                  default: state_q <= S_INIT_PRE;
                endcase
              end
            end
          endcase
        end
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = ^{PRDATA[31:8], cmd_data_i[2:0]};

endmodule
